// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes issued by the decoder and the
// sequential multiplier's state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    AND_OP   = 4'd0,
    OR_OP    = 4'd1,
    ADD_OP   = 4'd2,
    SLL_OP   = 4'd3,
    SRL_OP   = 4'd4,
    SUB_OP   = 4'd6,
    SLT_OP   = 4'd7,
    MUL_OP   = 4'd8,
    MULH_OP  = 4'd9,
    MULHU_OP = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_step.sv
// One radix-2^STEP_BITS iteration: adds mcand * mplier_slice into acc.
module mult_step
  import alu_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int STEP_BITS = 2
) (
  input  logic [ACC_W-1:0]     acc,
  input  logic [ACC_W-1:0]     mcand,
  input  logic [STEP_BITS-1:0] mplier_slice,
  output logic [ACC_W-1:0]     acc_next
);

  logic [STEP_BITS-1:0][ACC_W-1:0] pp;

  // one shifted copy of the multiplicand per slice bit
  for (genvar i = 0; i < STEP_BITS; i++) begin : g_pp
    assign pp[i] = mplier_slice[i] ? (mcand << i) : '0;
  end

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < STEP_BITS; i++) acc_next = acc_next + pp[i];
  end

endmodule

// File: rtl/mult_seq_unit.sv
// Iterative EX-stage multiplier: stalls the pipeline for MUL and returns the
// product after N = DATA_W/STEP_BITS cycles. MULT_SEQ_MULH_EN adds MULH/MULHU.
module mult_seq_unit
  import alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              stall,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  localparam int N     = DATA_W / STEP_BITS;
  localparam int CNT_W = $clog2(N + 1);
`ifdef MULT_SEQ_MULH_EN
  localparam int ACC_W = 2 * DATA_W;
`else
  localparam int ACC_W = DATA_W;
`endif

  mult_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc, acc_next, mcand, mcand_init;
  logic [DATA_W-1:0] mplier, mplier_init, final_res;
  logic              is_mul, start, last_step;

  assign start     = valid_in && is_mul && !flush;
  assign last_step = (cnt == CNT_W'(1));

`ifdef MULT_SEQ_MULH_EN
  logic              sel_signed, sel_hi, op_hi, op_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [ACC_W-1:0]  prod;

  // MULH runs on magnitudes; the sign is restored on the final product
  always_comb begin
    sel_signed  = (alu_control == MULH_OP);
    sel_hi      = sel_signed || (alu_control == MULHU_OP);
    is_mul      = (alu_control == MUL_OP) || sel_hi;
    a_mag       = (sel_signed && operand_a[DATA_W-1]) ? -operand_a : operand_a;
    b_mag       = (sel_signed && operand_b[DATA_W-1]) ? -operand_b : operand_b;
    mcand_init  = ACC_W'(a_mag);
    mplier_init = b_mag;
    prod        = op_neg ? -acc_next : acc_next;
    final_res   = op_hi ? prod[ACC_W-1:DATA_W] : prod[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_hi  <= 1'b0;
      op_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      op_hi  <= sel_hi;
      op_neg <= sel_signed && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
    end
  end
`else
  always_comb begin
    is_mul      = (alu_control == MUL_OP);
    mcand_init  = operand_a;
    mplier_init = operand_b;
    final_res   = acc_next;
  end
`endif

  mult_step #(
    .ACC_W    (ACC_W),
    .STEP_BITS(STEP_BITS)
  ) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier_slice(mplier[STEP_BITS-1:0]),
    .acc_next    (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = BUSY;
        BUSY:    if (last_step) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE:    stall = start;
      BUSY:    stall = 1'b1;
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  // operands are latched at issue so EX-input changes while BUSY are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= mcand_init;
          mplier <= mplier_init;
          acc    <= '0;
          cnt    <= CNT_W'(N);
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << STEP_BITS;
          mplier <= mplier >> STEP_BITS;
          cnt    <= cnt - CNT_W'(1);
          if (last_step) result <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_unit.sv
// Directed + randomized bench for mult_seq_unit against a plain-arithmetic
// product model; MULH/MULHU cases run when MULT_SEQ_MULH_EN is defined.
module tb_mult_seq_unit;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush;
  logic [3:0]  alu_control;
  logic [31:0] operand_a, operand_b;
  logic        stall, result_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_seq_unit #(.DATA_W(32), .STEP_BITS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .flush       (flush),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .stall       (stall),
    .result      (result),
    .result_valid(result_valid)
  );

  function automatic logic [31:0] ref_prod(input logic [3:0] code,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        u;
    logic signed [63:0] s;
    u = {32'd0, a} * {32'd0, b};
    s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (code)
      4'd9:    return s[63:32];
      4'd10:   return u[63:32];
      default: return u[31:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue an op in cycle 0, scramble EX inputs while busy, expect result in cycle 17
  task automatic run_mul(input string tag, input logic [3:0] code,
                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    exp = ref_prod(code, a, b);
    tick();
    valid_in = 1'b1; flush = 1'b0; alu_control = code; operand_a = a; operand_b = b;
    #1;
    chk({tag, ":issue_stall"}, 32'(stall), 32'd1);
    chk({tag, ":issue_rv"}, 32'(result_valid), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      operand_a = $urandom; operand_b = $urandom; alu_control = 4'($urandom_range(0, 15));
      #1;
      chk({tag, ":busy_stall"}, 32'(stall), 32'd1);
      chk({tag, ":busy_rv"}, 32'(result_valid), 32'd0);
    end
    tick();
    valid_in = 1'b0;
    #1;
    chk({tag, ":done_stall"}, 32'(stall), 32'd0);
    chk({tag, ":done_rv"}, 32'(result_valid), 32'd1);
    chk({tag, ":result"}, result, exp);
  endtask

  // ops that must never stall or produce a result
  task automatic run_idle(input string tag, input logic [3:0] code, input logic v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      valid_in = v; flush = 1'b0; alu_control = code;
      operand_a = $urandom; operand_b = $urandom;
      #1;
      chk({tag, ":stall"}, 32'(stall), 32'd0);
      chk({tag, ":rv"}, 32'(result_valid), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] nonmul [$];
    logic [3:0] code;
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; alu_control = 4'd0;
    operand_a = '0; operand_b = '0;
    tick();
    tick();
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_rv", 32'(result_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    run_mul("mul_3x5", 4'd8, 32'd3, 32'd5);
    run_mul("mul_ffff_x2", 4'd8, 32'hFFFF_FFFF, 32'd2);
    run_mul("mul_m3x7", 4'd8, 32'hFFFF_FFFD, 32'd7);
    run_idle("add", 4'd2, 1'b1, 4);
    run_idle("mul_novalid", 4'd8, 1'b0, 4);

    // flush during BUSY cycle 5
    tick();
    valid_in = 1'b1; alu_control = 4'd8; operand_a = 32'd6; operand_b = 32'd7;
    #1;
    chk("flush:issue_stall", 32'(stall), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) flush = 1'b1;
      #1;
      chk("flush:busy_stall", 32'(stall), 32'd1);
    end
    tick();
    flush = 1'b0; valid_in = 1'b0;
    #1;
    chk("flush:idle_stall", 32'(stall), 32'd0);
    chk("flush:idle_rv", 32'(result_valid), 32'd0);
    run_idle("flush:after", 4'd8, 1'b0, 16);
    run_mul("mul_2x2", 4'd8, 32'd2, 32'd2);

    // back-to-back: second MUL enters right after DONE
    run_mul("b2b_10x10", 4'd8, 32'd10, 32'd10);
    run_mul("b2b_0x123", 4'd8, 32'd0, 32'h123);
    tick();
    #1;
    chk("b2b:rv_one_cycle", 32'(result_valid), 32'd0);

    for (int i = 0; i < 6; i++) run_mul("rand_mul", 4'd8, $urandom, $urandom);
    run_mul("mul_nonzero", 4'd8, 32'h1234_5678, 32'h0000_0F0F);

`ifdef MULT_SEQ_MULH_EN
    nonmul = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd11, 4'd15};
    run_mul("mulh_min_x2", 4'd9, 32'h8000_0000, 32'd2);
    run_mul("mulhu_min_x2", 4'd10, 32'h8000_0000, 32'd2);
    run_mul("mulh_m1xm1", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      run_mul("rand_mulh", 4'd9, $urandom, $urandom);
      run_mul("rand_mulhu", 4'd10, $urandom, $urandom);
    end
`else
    nonmul = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd10, 4'd15};
    run_idle("mulh_disabled", 4'd9, 1'b1, 3);
    run_idle("mulhu_disabled", 4'd10, 1'b1, 3);
`endif
    for (int i = 0; i < 6; i++) begin
      code = nonmul[$urandom_range(0, nonmul.size() - 1)];
      run_idle("rand_nonmul", code, 1'b1, 2);
    end

    // reset during BUSY cycle 8
    run_mul("pre_rst", 4'd8, 32'd9, 32'd9);
    tick();
    valid_in = 1'b1; alu_control = 4'd8; operand_a = 32'h1234; operand_b = 32'h55;
    #1;
    chk("rst:issue_stall", 32'(stall), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) rst = 1'b1;
      #1;
      chk("rst:busy_stall", 32'(stall), 32'd1);
    end
    tick();
    rst = 1'b0; valid_in = 1'b0;
    #1;
    chk("rst:stall", 32'(stall), 32'd0);
    chk("rst:rv", 32'(result_valid), 32'd0);
    chk("rst:result", result, 32'd0);
    run_idle("rst:after", 4'd8, 1'b0, 12);
    run_mul("post_rst", 4'd8, 32'h1234, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_unit.md
Name: mult_seq_unit

Overview:
- Iterative integer multiplier in the EX stage, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code alongside the ALU.
- When the code is MUL (4'd8), it freezes the pipeline through a stall output, computes the product over several cycles, then presents the result for EX/MEM write-back.
- All other codes pass through untouched: no stall, no result.

Parameters:
- DATA_W, 32: operand and result width.
- STEP_BITS, 2: multiplier bits consumed per cycle; must divide DATA_W; N = DATA_W/STEP_BITS iteration cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  a valid instruction is present in EX this cycle.
- flush  in  1  synchronous squash of EX (branch taken / hazard unit).
- alu_control  in  4  ALU control code from the decoder.
- operand_a  in  DATA_W  multiplicand (rs1 after forwarding).
- operand_b  in  DATA_W  multiplier (rs2 after forwarding).
- stall  out  1  freeze PC, IF/ID, ID/EX; hold EX inputs stable.
- result  out  DATA_W  product; valid only while result_valid=1.
- result_valid  out  1  one-cycle pulse; EX result mux selects result over ALU output.

Behaviour:
- States: IDLE, BUSY, DONE. Iteration counter is clog2(N+1) bits.
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, counter=0, accumulator=0, result=0, result_valid=0.
  - stall=0 from the following cycle.
- IDLE:
  - stall = valid_in && alu_control==MUL_OP && !flush (combinational).
  - On that condition: latch operands, clear accumulator, counter=N, go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - stall=1 every cycle.
  - Each cycle: add (multiplicand × low STEP_BITS of multiplier) into the accumulator; shift multiplicand left by STEP_BITS, multiplier right by STEP_BITS; decrement counter.
  - Go to DONE on the cycle the counter reaches 0.
- DONE:
  - stall=0, result_valid=1, result = low DATA_W bits of the accumulator.
  - Pipeline advances at the end of this cycle; unconditionally return to IDLE, so the same instruction never re-triggers.
- Latency: issue cycle 0 (stall=1); BUSY cycles 1..N (stall=1); DONE at cycle N+1 (stall=0, result_valid=1). Default N=16, so 17 stall cycles and the result appears in cycle 17.
- Back-to-back MULs: the second MUL enters EX in cycle N+2 and starts a fresh IDLE→BUSY sequence; no zero-gap overlap.
- Arithmetic:
  - Low-half product is identical for signed and unsigned operands; no sign handling is needed for MUL.
  - Accumulator is DATA_W bits; overflow above DATA_W is discarded.
- flush has priority over everything except rst: from any state, go to IDLE next cycle with result_valid=0 and no result.
- Operand changes while BUSY are ignored; only the latched copies are used.
- alu_control changes while BUSY are ignored.

Optional Feature:
- Macro: MULT_SEQ_MULH_EN.
- Defined:
  - Also accepts MULH_OP=4'd9 (signed×signed, upper half) and MULHU_OP=4'd10 (unsigned×unsigned, upper half).
  - Accumulator widens to 2*DATA_W.
  - For MULH, operand magnitudes are taken at issue; the product is negated in DONE when the operand signs differ.
  - result = upper DATA_W bits for MULH/MULHU, lower DATA_W bits for MUL. Latency unchanged.
- Undefined: codes 9/10 are treated like any non-MUL code (no stall, no result); accumulator stays DATA_W bits.

Decomposition:
- Shared package/header alu_pkg holds:
  - ALU control codes: AND_OP=0, OR_OP=1, ADD_OP=2, SLL_OP=3, SRL_OP=4, SUB_OP=6, SLT_OP=7, MUL_OP=8, MULH_OP=9, MULHU_OP=10.
  - State encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - The decoder and this unit both import it.
- One sub-module, mult_step: combinational partial-product generator and adder, taking {acc, mcand, mplier_slice} and producing next acc. Instantiated once in this unit.

Test Plan:
- MUL 3×5, valid_in=1 → stall high cycles 0–16; cycle 17: result=0x0000000F, result_valid=1, stall=0.
- MUL 0xFFFFFFFF×0x00000002 → result=0xFFFFFFFE; MUL 0xFFFFFFFD×7 (−3×7) → 0xFFFFFFEB.
- ADD code 4'd2, and MUL with valid_in=0 → stall=0 and result_valid=0 on every cycle.
- MUL 6×7 with flush at BUSY cycle 5 → IDLE at cycle 6; no result_valid; next MUL 2×2 → 0x4 after a full 17 cycles.
- Back-to-back MUL 10×10 then 0×123 → results 0x64 and 0x0, each after its own 17 stall cycles; result_valid exactly one cycle each. rst at BUSY cycle 8 → stall=0, result_valid=0 next cycle, state IDLE.
- With MULT_SEQ_MULH_EN: MULH 0x80000000×2 → 0xFFFFFFFF; MULHU 0x80000000×2 → 0x00000001; MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
